// File: rtl/hilo_mdu_ctrl_if.sv
// EX-stage HI/LO sequencer bundle: operation request, operands, current HI/LO,
// and the stall/busy/write-port responses.
interface hilo_mdu_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] hi_cur;
    logic [31:0] lo_cur;
    logic        annul;
    logic        stall_o;
    logic        busy_o;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output op_valid, op, opa, opb, hi_cur, lo_cur, annul,
        input  stall_o, busy_o, hilo_we, hi_o, lo_o
    );

    modport slave (
        input  op_valid, op, opa, opb, hi_cur, lo_cur, annul,
        output stall_o, busy_o, hilo_we, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO multiply/divide sequencer: single-cycle MULT/MULTU/MTHI/MTLO and a
// 32-step restoring divider, driving one registered HI/LO write pulse per op.
module hilo_mdu_ctrl #(
    parameter int DIV_ITER = 32
) (
    input  logic             clk,
    input  logic             rst,
    hilo_mdu_ctrl_if.slave   bus
);

    localparam int CW = $clog2(DIV_ITER);
    localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITER - 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_rem;
    logic [31:0]     r_quo;
    logic [31:0]     r_dvs;
    logic            r_qsign;
    logic            r_rsign;
    logic            r_we;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;

    state_t          w_state_nx;
    logic [CW-1:0]   w_cnt_nx;
    logic [31:0]     w_rem_nx;
    logic [31:0]     w_quo_nx;
    logic [31:0]     w_dvs_nx;
    logic            w_qsign_nx;
    logic            w_rsign_nx;
    logic            w_we_nx;
    logic [31:0]     w_hi_nx;
    logic [31:0]     w_lo_nx;

    logic            w_is_div;
    logic            w_op_ok;
    logic            w_accept;
    logic signed [63:0] w_prod_s;
    logic [63:0]     w_prod_u;
    logic            w_sa;
    logic            w_sb;
    logic [31:0]     w_abs_a;
    logic [31:0]     w_abs_b;
    logic [32:0]     w_rem_sh;
    logic [32:0]     w_diff;
    logic            w_qbit;
    logic [31:0]     w_step_rem;
    logic [31:0]     w_step_quo;
    logic [31:0]     w_q_fix;
    logic [31:0]     w_r_fix;

    // Operation decode, multiply products and one restoring divide step.
    always_comb begin
        w_is_div   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        w_op_ok    = (bus.op != 3'b000) && (bus.op != 3'b111);
        w_accept   = (r_state == S_IDLE) && bus.op_valid && !bus.annul && w_op_ok;
        w_prod_s   = $signed(bus.opa) * $signed(bus.opb);
        w_prod_u   = {32'd0, bus.opa} * {32'd0, bus.opb};
        w_sa       = (bus.op == OP_DIV) && bus.opa[31];
        w_sb       = (bus.op == OP_DIV) && bus.opb[31];
        w_abs_a    = w_sa ? (32'd0 - bus.opa) : bus.opa;
        w_abs_b    = w_sb ? (32'd0 - bus.opb) : bus.opb;
        // 33-bit partial remainder; bit 32 of the difference is the borrow.
        w_rem_sh   = {r_rem, r_quo[31]};
        w_diff     = w_rem_sh - {1'b0, r_dvs};
        w_qbit     = !w_diff[32];
        w_step_rem = w_qbit ? w_diff[31:0] : w_rem_sh[31:0];
        w_step_quo = {r_quo[30:0], w_qbit};
        w_q_fix    = r_qsign ? (32'd0 - w_step_quo) : w_step_quo;
        w_r_fix    = r_rsign ? (32'd0 - w_step_rem) : w_step_rem;
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rem_nx   = r_rem;
        w_quo_nx   = r_quo;
        w_dvs_nx   = r_dvs;
        w_qsign_nx = r_qsign;
        w_rsign_nx = r_rsign;
        w_we_nx    = 1'b0;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (bus.op)
                        OP_MULT: begin
                            w_we_nx = 1'b1;
                            w_hi_nx = w_prod_s[63:32];
                            w_lo_nx = w_prod_s[31:0];
                        end
                        OP_MULTU: begin
                            w_we_nx = 1'b1;
                            w_hi_nx = w_prod_u[63:32];
                            w_lo_nx = w_prod_u[31:0];
                        end
                        OP_MTHI: begin
                            w_we_nx = 1'b1;
                            w_hi_nx = bus.opa;
                            w_lo_nx = bus.lo_cur;
                        end
                        OP_MTLO: begin
                            w_we_nx = 1'b1;
                            w_hi_nx = bus.hi_cur;
                            w_lo_nx = bus.opa;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.opb == 32'd0) begin
                                w_we_nx    = 1'b1;
                                w_hi_nx    = bus.opa;
                                w_lo_nx    = 32'hFFFF_FFFF;
                                w_state_nx = S_DONE;
                            end else begin
                                w_rem_nx   = 32'd0;
                                w_quo_nx   = w_abs_a;
                                w_dvs_nx   = w_abs_b;
                                w_qsign_nx = w_sa ^ w_sb;
                                w_rsign_nx = w_sa;
                                w_cnt_nx   = {CW{1'b0}};
                                w_state_nx = S_RUN;
                            end
                        end
                        default: begin
                            w_we_nx = 1'b0;
                        end
                    endcase
                end else begin
                    w_we_nx = 1'b0;
                end
            end
            S_RUN: begin
                // A flush abandons the divide; the held instruction is gone.
                if (bus.annul) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = {CW{1'b0}};
                end else begin
                    w_rem_nx = w_step_rem;
                    w_quo_nx = w_step_quo;
                    if (r_cnt == LAST_ITER) begin
                        w_we_nx    = 1'b1;
                        w_hi_nx    = w_r_fix;
                        w_lo_nx    = w_q_fix;
                        w_cnt_nx   = {CW{1'b0}};
                        w_state_nx = S_DONE;
                    end else begin
                        w_cnt_nx = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = {CW{1'b0}};
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_dvs   <= 32'd0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_we    <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_rem   <= w_rem_nx;
            r_quo   <= w_quo_nx;
            r_dvs   <= w_dvs_nx;
            r_qsign <= w_qsign_nx;
            r_rsign <= w_rsign_nx;
            r_we    <= w_we_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
        end
    end

    // Stall covers the divide accept cycle and every RUN cycle, never DONE.
    assign bus.stall_o = ((r_state == S_IDLE) && bus.op_valid && !bus.annul && w_is_div)
                         || (r_state == S_RUN);
    assign bus.busy_o  = (r_state != S_IDLE);
    assign bus.hilo_we = r_we;
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;

endmodule
